// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM
// pipeline register. Only WIDTH = 32 is meaningful (shift amounts use [4:0]).
module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallM,
    input  logic             FlushM,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             JumpE,
    input  logic             BranchE,
    input  logic             ALUSrcE,
    input  logic [1:0]       ResultSrcE,
    input  logic [2:0]       ALUControlE,
    input  logic [4:0]       RdE,
    input  logic [WIDTH-1:0] RD1E,
    input  logic [WIDTH-1:0] RD2E,
    input  logic [WIDTH-1:0] ImmExtE,
    input  logic [WIDTH-1:0] PCE,
    input  logic [WIDTH-1:0] PCPlus4E,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ResultW,
    output logic             PCSrcE,
    output logic [WIDTH-1:0] PCTargetE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [4:0]       RdM,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] PCPlus4M
);

    logic [WIDTH-1:0] src_a, src_b, wdata_e, alu_y;
    logic             zero_e, rw_e;

    // Forwarding muxes; code 11 is unused by the hazard unit and falls back to the register file.
    always_comb begin
        src_a   = RD1E;
        wdata_e = RD2E;
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM;
            default: src_a = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   wdata_e = ResultW;
            2'b10:   wdata_e = ALUResultM;
            default: wdata_e = RD2E;
        endcase
        src_b = ALUSrcE ? ImmExtE : wdata_e;
    end

    // ALU; add/sub wrap naturally, slt is signed, shifts use the low five bits of B.
    always_comb begin
        alu_y = '0;
        case (ALUControlE)
            3'b000: alu_y = src_a + src_b;
            3'b001: alu_y = src_a - src_b;
            3'b010: alu_y = src_a & src_b;
            3'b011: alu_y = src_a | src_b;
            3'b100: alu_y = src_a ^ src_b;
            3'b101: alu_y = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b110: alu_y = src_a << src_b[4:0];
            3'b111: alu_y = src_a >> src_b[4:0];
            default: alu_y = '0;
        endcase
    end

    assign zero_e    = (alu_y == '0);
    assign PCTargetE = PCE + ImmExtE;
    // Redirect is purely combinational so it is blind to stall/flush/reset of EX/MEM.
    assign PCSrcE    = JumpE | (BranchE & zero_e);
    // Writes to x0 are squashed here so nothing downstream needs to check RdM.
    assign rw_e      = RegWriteE & (RdE != 5'd0);

    // EX/MEM register: reset beats flush beats stall beats load.
    always_ff @(posedge clk) begin
        if (reset || FlushM) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            RdM        <= 5'd0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else if (!StallM) begin
            RegWriteM  <= rw_e;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RdM        <= RdE;
            ALUResultM <= alu_y;
            WriteDataM <= wdata_e;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: WIDTH, 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 StallM  in  1  hold EX/MEM register contents.
REQ-005 FlushM  in  1  load a bubble into EX/MEM register.
REQ-006 RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  in  1 each  execute-stage control from ID/EX.
REQ-007 ResultSrcE  in  2  writeback select, passed through.
REQ-008 ALUControlE  in  3  ALU operation select.
REQ-009 RdE  in  5  destination register index.
REQ-010 RD1E, RD2E, ImmExtE, PCE, PCPlus4E  in  32 each  operands, immediate, PC values from ID/EX.
REQ-011 ForwardAE, ForwardBE  in  2 each  operand source select from hazard unit.
REQ-012 ResultW  in  32  writeback-stage result for forwarding.
REQ-013 PCSrcE  out  1  redirect fetch (combinational).
REQ-014 PCTargetE  out  32  branch/jump target (combinational).
REQ-015 RegWriteM, MemWriteM  out  1 each  registered control.
REQ-016 ResultSrcM  out  2  registered writeback select.
REQ-017 RdM  out  5  registered destination index.
REQ-018 ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered data.

Function
REQ-019 SrcAE SHALL be RD1E/ResultW/ALUResultM for ForwardAE 00/01/10; 11 SHALL select RD1E.
REQ-020 WriteDataE SHALL be RD2E/ResultW/ALUResultM for ForwardBE 00/01/10; 11 SHALL select RD2E.
REQ-021 SrcBE SHALL be ImmExtE when ALUSrcE=1, else WriteDataE.
REQ-022 ALU SHALL compute per ALUControlE: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 signed slt (result 0 or 1), 110 sll by SrcBE[4:0], 111 srl by SrcBE[4:0].
REQ-023 Add/sub SHALL wrap modulo 2^32; no overflow flag.
REQ-024 ZeroE SHALL be 1 iff ALU result equals 0.
REQ-025 PCTargetE SHALL be PCE + ImmExtE, modulo 2^32.
REQ-026 PCSrcE SHALL be JumpE | (BranchE & ZeroE), independent of StallM, FlushM, reset.
REQ-027 EX/MEM register latency SHALL be exactly one cycle from E inputs to M outputs.
REQ-028 Update priority each edge: reset > FlushM > StallM > normal load.
REQ-029 Normal load: M outputs take RegWriteE', MemWriteE, ResultSrcE, RdE, ALU result, WriteDataE, PCPlus4E.
REQ-030 RegWriteE' SHALL be RegWriteE & (RdE != 0); writes to x0 never propagate.
REQ-031 StallM=1 (no flush, no reset): all M outputs hold previous values.
REQ-032 FlushM=1 (no reset): all M outputs become 0, regardless of StallM.
REQ-033 Forwarding from ALUResultM SHALL use the current registered value, including while stalled.

Reset
REQ-034 On reset=1 at a rising edge all M outputs SHALL become 0; combinational outputs are unaffected.
REQ-035 Reset asserted mid-stall or mid-flush SHALL produce the all-zero state on that edge.

Verification
REQ-036 RD1E=5, RD2E=7, ALUSrcE=0, ALUControlE=000, Forward=00, RdE=3, RegWriteE=1 -> next cycle ALUResultM=12, RdM=3, RegWriteM=1.
REQ-037 ALUControlE=101, SrcA=0xFFFFFFFF, SrcB=1 -> ALUResultM=1; ALUControlE=001, SrcA=0, SrcB=1 -> ALUResultM=0xFFFFFFFF.
REQ-038 BranchE=1, RD1E=RD2E=9, ALUControlE=001, PCE=0x100, ImmExtE=0xFFFFFFF8 -> PCSrcE=1, PCTargetE=0xF8 same cycle.
REQ-039 ForwardAE=10 with ALUResultM=0x40, ForwardBE=01 with ResultW=2, ALUControlE=000 -> ALUResultM=0x42 next cycle.
REQ-040 StallM=1 and FlushM=1 together with valid inputs -> all M outputs 0; then StallM=1 alone -> outputs hold 0.
REQ-041 RegWriteE=1, RdE=0 -> RegWriteM=0; reset asserted while StallM=1 -> all M outputs 0 next edge.
